// File: rtl/digits_collect.sv
// Decimal keypad entry: BCD digits in, MSD first, binary value out on commit.
// Optional backspace (divide-by-10 path) enabled with DIGITS_BACKSPACE_EN.
module digits_collect #(
  parameter int NUM = 4,
  parameter int W   = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       digit_valid,
  input  logic [3:0]                 digit,
  input  logic                       commit,
  input  logic                       clear,
  input  logic                       backspace,
  output logic [W-1:0]               acc,
  output logic [$clog2(NUM+1)-1:0]   count,
  output logic [W-1:0]               result,
  output logic                       result_valid,
  output logic                       err
);

  localparam int CW = $clog2(NUM+1);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    DONE
  } state_t;

  state_t state;

  logic [W+3:0] acc_x;
  logic [W+3:0] prod;
  logic         dig_bad;

  // Four extra bits hold acc*10+digit without wrap, so overflow is exact.
  assign acc_x   = {4'b0000, acc};
  assign prod    = acc_x * (W+4)'(10) + (W+4)'(digit);
  assign dig_bad = (digit > 4'd9)
                 | (count == CW'(NUM))
                 | (|prod[W+3:W]);

`ifdef DIGITS_BACKSPACE_EN
  logic [W-1:0] acc_div;
  assign acc_div = acc / W'(10);
`else
  logic unused_bs;
  assign unused_bs = backspace;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      priority case (1'b1)
        clear: begin
          acc   <= '0;
          count <= '0;
          state <= IDLE;
        end
        commit: begin
          if (state == ENTRY) begin
            result       <= acc;
            result_valid <= 1'b1;
            acc          <= '0;
            count        <= '0;
            state        <= DONE;
          end else begin
            err <= 1'b1;
          end
        end
`ifdef DIGITS_BACKSPACE_EN
        backspace: begin
          if (state == ENTRY) begin
            acc   <= acc_div;
            count <= count - CW'(1);
            if (count == CW'(1))
              state <= IDLE;
          end else begin
            err <= 1'b1;
          end
        end
`endif
        // acc is zero outside ENTRY, so prod is just the new digit there.
        digit_valid: begin
          if (dig_bad) begin
            err <= 1'b1;
          end else begin
            acc   <= prod[W-1:0];
            count <= count + CW'(1);
            state <= ENTRY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digits_collect.sv
// Scoreboard bench for digits_collect: model predicts per-cycle outputs.
// Builds with or without DIGITS_BACKSPACE_EN.
module tb_digits_collect;

  localparam int NUM = 4;
  localparam int W   = 10;
  localparam int CW  = $clog2(NUM+1);
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          digit_valid = 1'b0;
  logic [3:0]    digit = 4'd0;
  logic          commit = 1'b0;
  logic          clear = 1'b0;
  logic          backspace = 1'b0;
  logic [W-1:0]  acc;
  logic [CW-1:0] count;
  logic [W-1:0]  result;
  logic          result_valid;
  logic          err;

  digits_collect #(.NUM(NUM), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .commit       (commit),
    .clear        (clear),
    .backspace    (backspace),
    .acc          (acc),
    .count        (count),
    .result       (result),
    .result_valid (result_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    acc;
    int    cnt;
    int    res;
    int    rv;
    int    er;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int m_acc = 0;
  int m_cnt = 0;
  int m_res = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit dv, input int d,
                       input bit cm, input bit cl, input bit bs,
                       output exp_t e);
    int nv;
    e.rv = 0;
    e.er = 0;
    if (!r) begin
      m_acc = 0;
      m_cnt = 0;
      m_res = 0;
    end else if (cl) begin
      m_acc = 0;
      m_cnt = 0;
    end else if (cm) begin
      if (m_cnt > 0) begin
        m_res = m_acc;
        e.rv  = 1;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        e.er = 1;
      end
`ifdef DIGITS_BACKSPACE_EN
    end else if (bs) begin
      if (m_cnt > 0) begin
        m_acc = m_acc / 10;
        m_cnt = m_cnt - 1;
      end else begin
        e.er = 1;
      end
`endif
    end else if (dv) begin
      nv = m_acc * 10 + d;
      if (d > 9 || m_cnt == NUM || nv > MAXV) begin
        e.er = 1;
      end else begin
        m_acc = nv;
        m_cnt = m_cnt + 1;
      end
    end
    if (bs && !r) e.er = 0;
    e.acc = m_acc;
    e.cnt = m_cnt;
    e.res = m_res;
  endtask

  task automatic step(input string tag, input bit r = 1'b1,
                      input bit dv = 1'b0, input int d = 0,
                      input bit cm = 1'b0, input bit cl = 1'b0,
                      input bit bs = 1'b0);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst_n       = r;
    digit_valid = dv;
    digit       = 4'(d);
    commit      = cm;
    clear       = cl;
    backspace   = bs;
    model(r, dv, d, cm, cl, bs, e);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      chk({g.tag, "_acc"}, int'(acc), g.acc);
      chk({g.tag, "_cnt"}, int'(count), g.cnt);
      chk({g.tag, "_res"}, int'(result), g.res);
      chk({g.tag, "_rv"}, int'(result_valid), g.rv);
      chk({g.tag, "_err"}, int'(err), g.er);
    end
  endtask

  task automatic dig(input string tag, input int d);
    step(tag, 1'b1, 1'b1, d);
  endtask

  initial begin
    step("rst0", 1'b0);
    step("rst1", 1'b0);
    step("idle");

    dig("d1", 1);
    dig("d2", 2);
    dig("d3", 3);
    step("cm123", 1'b1, 1'b0, 0, 1'b1);
    step("done");

    dig("o1", 1);
    dig("o0", 0);
    dig("o2", 2);
    dig("o4ovf", 4);
    dig("o3", 3);
    dig("o5full", 5);
    step("cm1023", 1'b1, 1'b0, 0, 1'b1);

    step("clr", 1'b1, 1'b0, 0, 1'b0, 1'b1);
    dig("d12bad", 12);
    step("cmidle", 1'b1, 1'b0, 0, 1'b1);

    dig("c4", 4);
    dig("c5", 5);
    step("clrcm", 1'b1, 1'b0, 0, 1'b1, 1'b1);
    step("after_clr");

    dig("z0a", 0);
    dig("z0b", 0);
    dig("z0c", 0);
    dig("z7", 7);
    dig("z8full", 8);
    step("cmdig", 1'b1, 1'b1, 3, 1'b1);
    dig("fresh", 6);
    step("clr2", 1'b1, 1'b0, 0, 1'b0, 1'b1);

    dig("b9", 9);
    dig("b8", 8);
    dig("b7", 7);
    step("bs1", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step("bs2", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step("bs3", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step("bs4", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    step("bsdig", 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b1);
    step("clr3", 1'b1, 1'b0, 0, 1'b0, 1'b1);

    dig("r5", 5);
    dig("r6", 6);
    step("rstmid", 1'b0, 1'b1, 7);
    dig("r3", 3);

    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 15);
      step("rnd", ($urandom_range(0, 63) != 0),
           (sel < 9), $urandom_range(0, 11),
           (sel == 9 || sel == 10), (sel == 11),
           (sel == 12 || sel == 13));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
